// File: rtl/cla_pipe_adder_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead adder.
//   def_width  : default operand/result width
//   def_group  : default bits resolved per pipeline stage
//   num_groups : stage count for a given width/group split
package cla_pipe_adder_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefGroup = 4;

    function automatic int unsigned num_groups(input int unsigned width,
                                               input int unsigned group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// Combinational carry-lookahead group of GROUP bits.
// Ports:
//   a, b  in  GROUP  operand slices
//   cin   in  1      carry into the group
//   s     out GROUP  sum slice
//   cout  out 1      carry out of the group
//   g, p  out 1      group generate / propagate
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             g,
    output logic             p
);

    logic [GROUP-1:0] gi;
    logic [GROUP-1:0] pi;
    logic [GROUP:0]   c;
    logic             term;

    assign gi = a & b;
    assign pi = a ^ b;

    // Every carry is the fully expanded sum of products, so no bit ripples
    // through its neighbour: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    always_comb begin
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) begin
                term = term & pi[j];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = gi[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & pi[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    always_comb begin
        g = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            logic t;
            t = gi[j];
            for (int k = j + 1; k < GROUP; k++) begin
                t = t & pi[k];
            end
            g = g | t;
        end
    end

    assign p    = &pi;
    assign s    = pi ^ c[GROUP-1:0];
    assign cout = c[GROUP];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// One GROUP-bit lookahead group is resolved per stage; the carry between
// groups is registered, so latency is NG = WIDTH/GROUP cycles at 1/cycle.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready = !out_valid | out_ready)
//   a, b                 WIDTH-bit operands
//   cin                  carry-in, ignored when sub=1
//   sub                  1: a - b, 0: a + b + cin
//   out_valid, out_ready output handshake
//   s                    result modulo 2^WIDTH
//   cout                 carry out of MSB (for subtract, 1 = no borrow)
//   ovf                  signed overflow
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned GROUP = DefGroup
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NG = num_groups(WIDTH, GROUP);

    if ((GROUP == 0) || ((WIDTH % GROUP) != 0)) begin : g_bad_split
        $error("cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP");
    end

    // Stage registers
    logic [NG-1:0]    v_q;
    logic [NG-1:0]    c_q;
    logic [WIDTH-1:0] opa_q [NG];
    logic [WIDTH-1:0] opb_q [NG];
    logic [WIDTH-1:0] s_q   [NG];
    logic             msb_q;

    // Stage inputs and next state
    logic [NG-1:0]    v_in;
    logic [NG-1:0]    c_in;
    logic [WIDTH-1:0] opa_in [NG];
    logic [WIDTH-1:0] opb_in [NG];
    logic [WIDTH-1:0] s_in   [NG];
    logic [WIDTH-1:0] s_nxt  [NG];
    logic [GROUP-1:0] grp_s  [NG];
    logic [NG-1:0]    grp_c;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic             msb_nxt;
    logic             en;

    // Whole pipe moves together; a stalled output freezes every stage.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        for (int k = 0; k < NG; k++) begin
            if (k == 0) begin
                v_in[k]   = in_valid;
                opa_in[k] = a;
                opb_in[k] = sub ? ~b : b;
                c_in[k]   = sub | cin;
                s_in[k]   = '0;
            end else begin
                v_in[k]   = v_q[k-1];
                opa_in[k] = opa_q[k-1];
                opb_in[k] = opb_q[k-1];
                c_in[k]   = c_q[k-1];
                s_in[k]   = s_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_stage
        cla_group #(
            .GROUP(GROUP)
        ) u_grp (
            .a    (opa_in[k][k*GROUP +: GROUP]),
            .b    (opb_in[k][k*GROUP +: GROUP]),
            .cin  (c_in[k]),
            .s    (grp_s[k]),
            .cout (grp_c[k]),
            .g    (grp_g[k]),
            .p    (grp_p[k])
        );
    end

    // Group generate/propagate are not needed with one group per stage.
    logic unused_gp;
    assign unused_gp = ^{grp_g, grp_p};

    always_comb begin
        for (int k = 0; k < NG; k++) begin
            s_nxt[k] = s_in[k];
            s_nxt[k][k*GROUP +: GROUP] = grp_s[k];
        end
    end

    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign msb_nxt = opa_in[NG-1][WIDTH-1] ^ opb_in[NG-1][WIDTH-1] ^ grp_s[NG-1][GROUP-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            msb_q <= 1'b0;
            for (int k = 0; k < NG; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                s_q[k]   <= '0;
            end
        end else if (en) begin
            v_q   <= v_in;
            c_q   <= grp_c;
            msb_q <= msb_nxt;
            for (int k = 0; k < NG; k++) begin
                opa_q[k] <= opa_in[k];
                opb_q[k] <= opb_in[k];
                s_q[k]   <= s_nxt[k];
            end
        end
    end

    assign out_valid = v_q[NG-1];
    assign s         = s_q[NG-1];
    assign cout      = c_q[NG-1];
    assign ovf       = msb_q ^ c_q[NG-1];

endmodule
